// File: rtl/oclib_packet_fifo.sv
// oclib_packet_fifo: single-clock store-and-forward packet FIFO.
// A packet becomes visible at the output only after its last beat commits.
// Dropped (inDrop on the last beat) and oversize packets are discarded whole.
// Optional macro OCLIB_PACKET_FIFO_DROP_COUNT_EN builds a 16-bit saturating
// drop counter; without it dropCount is tied to zero.
module oclib_packet_fifo #(
    parameter int  Width       = 32,
    parameter int  Depth       = 64,
    parameter type DataType    = logic [Width-1:0],
    parameter int  AlmostFull  = Depth - 8,
    parameter int  AlmostEmpty = 8
) (
    input  logic                       clock,
    input  logic                       resetN,
    input  DataType                    inData,
    input  logic                       inValid,
    input  logic                       inLast,
    input  logic                       inDrop,
    output logic                       inReady,
    output DataType                    outData,
    output logic                       outLast,
    output logic                       outValid,
    input  logic                       outReady,
    output logic [$clog2(Depth+1)-1:0] level,
    output logic [$clog2(Depth+1)-1:0] packetCount,
    output logic                       almostFull,
    output logic                       almostEmpty,
    output logic                       dropPulse,
    output logic [15:0]                dropCount
);

    localparam int AW = $clog2(Depth);
    localparam int PW = AW + 1;
    localparam int LW = $clog2(Depth + 1);
    localparam int DW = $bits(DataType);

    if (Depth < 4 || (Depth & (Depth - 1)) != 0) begin : g_bad_depth
        $error("oclib_packet_fifo: Depth must be a power of two >= 4");
    end

    typedef logic [PW-1:0] ptr_t;
    typedef enum logic {PASS, DISCARD} state_e;

    state_e          state_q, state_d;
    ptr_t            wrPtr_q, wrPtr_d;
    ptr_t            commitPtr_q, commitPtr_d;
    ptr_t            rdPtr_q, rdPtr_d;
    ptr_t            memFill, fill_d;
    logic            outValid_q, outValid_d;
    logic            outLast_q;
    DataType         outData_q;
    logic [LW-1:0]   level_q, level_d;
    logic [LW-1:0]   pktCnt_q, pktCnt_d;
    logic            aFull_q, aEmpty_q;
    logic            dropPulse_q, dropPulse_d;
    logic            inReady_q, inReady_d;
    logic [DW:0]     mem_q [Depth];

    logic accept, wrEn, commit, rewind, overflow, discEnd, outPop, load;

    assign memFill  = wrPtr_q - rdPtr_q;
    assign accept   = inValid && inReady_q;
    assign wrEn     = accept && (state_q == PASS);
    assign commit   = wrEn && inLast && !inDrop;
    assign rewind   = wrEn && inLast && inDrop;
    // An uncommitted packet that would occupy every entry can never commit:
    // abandon it and swallow the rest of its beats.
    assign overflow = wrEn && !inLast && (memFill == ptr_t'(Depth - 1))
                      && (commitPtr_q == rdPtr_q);
    assign discEnd  = accept && (state_q == DISCARD) && inLast;
    assign outPop   = outValid_q && outReady && outLast_q;
    assign load     = (!outValid_q || outReady) && (rdPtr_q != commitPtr_q);

    // Next-state for pointers, state, counters and registered flags.
    always_comb begin
        wrPtr_d     = wrPtr_q;
        commitPtr_d = commitPtr_q;
        rdPtr_d     = rdPtr_q;
        state_d     = state_q;
        pktCnt_d    = pktCnt_q;
        outValid_d  = outValid_q;
        if (wrEn)               wrPtr_d = wrPtr_q + 1'b1;
        if (rewind || overflow) wrPtr_d = commitPtr_q;
        if (commit)             commitPtr_d = wrPtr_q + 1'b1;
        if (load)               rdPtr_d = rdPtr_q + 1'b1;
        if (overflow)           state_d = DISCARD;
        else if (discEnd)       state_d = PASS;
        if (commit && !outPop)  pktCnt_d = pktCnt_q + 1'b1;
        else if (!commit && outPop) pktCnt_d = pktCnt_q - 1'b1;
        if (load)               outValid_d = 1'b1;
        else if (outReady)      outValid_d = 1'b0;
        fill_d      = wrPtr_d - rdPtr_d;
        level_d     = LW'(fill_d) + LW'(outValid_d);
        inReady_d   = (state_d == DISCARD) || (fill_d < ptr_t'(Depth));
        dropPulse_d = rewind || discEnd;
    end

    // Control registers, output stage and flags.
    always_ff @(posedge clock) begin
        if (!resetN) begin
            state_q     <= PASS;
            wrPtr_q     <= '0;
            commitPtr_q <= '0;
            rdPtr_q     <= '0;
            outValid_q  <= 1'b0;
            outLast_q   <= 1'b0;
            outData_q   <= '0;
            level_q     <= '0;
            pktCnt_q    <= '0;
            aFull_q     <= 1'b0;
            aEmpty_q    <= 1'b1;
            dropPulse_q <= 1'b0;
            inReady_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            wrPtr_q     <= wrPtr_d;
            commitPtr_q <= commitPtr_d;
            rdPtr_q     <= rdPtr_d;
            outValid_q  <= outValid_d;
            if (load) begin
                outLast_q <= mem_q[rdPtr_q[AW-1:0]][DW];
                outData_q <= DataType'(mem_q[rdPtr_q[AW-1:0]][DW-1:0]);
            end
            level_q     <= level_d;
            pktCnt_q    <= pktCnt_d;
            aFull_q     <= int'(level_d) >= AlmostFull;
            aEmpty_q    <= int'(level_d) <= AlmostEmpty;
            dropPulse_q <= dropPulse_d;
            inReady_q   <= inReady_d;
        end
    end

    // Beat storage: {last, data}; contents are meaningless outside the pointers.
    always_ff @(posedge clock) begin
        if (resetN && wrEn) mem_q[wrPtr_q[AW-1:0]] <= {inLast, DW'(inData)};
    end

`ifdef OCLIB_PACKET_FIFO_DROP_COUNT_EN
    logic [15:0] dropCnt_q;

    // Saturating count of discarded packets, cleared only by reset.
    always_ff @(posedge clock) begin
        if (!resetN)                                 dropCnt_q <= '0;
        else if (dropPulse_d && dropCnt_q != 16'hFFFF) dropCnt_q <= dropCnt_q + 16'd1;
    end

    assign dropCount = dropCnt_q;
`else
    assign dropCount = 16'd0;
`endif

    assign inReady     = inReady_q;
    assign outData     = outData_q;
    assign outLast     = outLast_q;
    assign outValid    = outValid_q;
    assign level       = level_q;
    assign packetCount = pktCnt_q;
    assign almostFull  = aFull_q;
    assign almostEmpty = aEmpty_q;
    assign dropPulse   = dropPulse_q;

endmodule

// File: tb/tb_oclib_packet_fifo.sv
// Directed bench for oclib_packet_fifo (Depth=16, Width=8, AlmostFull=8, AlmostEmpty=2).
module tb_oclib_packet_fifo;

    logic        clock = 1'b0;
    logic        resetN;
    logic [7:0]  inData;
    logic        inValid, inLast, inDrop, inReady;
    logic [7:0]  outData;
    logic        outLast, outValid, outReady;
    logic [4:0]  level, packetCount;
    logic        almostFull, almostEmpty, dropPulse;
    logic [15:0] dropCount;

    int checks   = 0;
    int failures = 0;
    int expDrops = 0;

`ifdef OCLIB_PACKET_FIFO_DROP_COUNT_EN
    localparam bit DcEn = 1'b1;
`else
    localparam bit DcEn = 1'b0;
`endif

    oclib_packet_fifo #(.Width(8), .Depth(16), .AlmostFull(8), .AlmostEmpty(2)) dut (
        .clock(clock), .resetN(resetN),
        .inData(inData), .inValid(inValid), .inLast(inLast), .inDrop(inDrop),
        .inReady(inReady),
        .outData(outData), .outLast(outLast), .outValid(outValid), .outReady(outReady),
        .level(level), .packetCount(packetCount),
        .almostFull(almostFull), .almostEmpty(almostEmpty),
        .dropPulse(dropPulse), .dropCount(dropCount)
    );

    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic beat(input logic [7:0] d, input logic last, input logic drop);
        inValid = 1'b1; inData = d; inLast = last; inDrop = drop;
        step();
        inValid = 1'b0; inLast = 1'b0; inDrop = 1'b0;
    endtask

    task automatic checkReset(input string tag);
        check({tag, "_outValid"}, 32'(outValid), 0);
        check({tag, "_outLast"}, 32'(outLast), 0);
        check({tag, "_outData"}, 32'(outData), 0);
        check({tag, "_level"}, 32'(level), 0);
        check({tag, "_pktCnt"}, 32'(packetCount), 0);
        check({tag, "_aFull"}, 32'(almostFull), 0);
        check({tag, "_aEmpty"}, 32'(almostEmpty), 1);
        check({tag, "_dropPulse"}, 32'(dropPulse), 0);
        check({tag, "_dropCount"}, 32'(dropCount), 0);
        check({tag, "_inReady"}, 32'(inReady), 0);
    endtask

    initial begin
        resetN = 1'b0; inData = '0; inValid = 1'b0; inLast = 1'b0; inDrop = 1'b0;
        outReady = 1'b0;
        step(); step();
        checkReset("rst0");
        resetN = 1'b1;
        step();
        check("rdy_after_rst", 32'(inReady), 1);

        // 4-beat packet, streaming out
        outReady = 1'b1;
        for (int i = 0; i < 4; i++) begin
            beat(8'hA0 + 8'(i), i == 3, 1'b0);
            if (i < 3) check("t1_pkt_pending", 32'(packetCount), 0);
        end
        check("t1_pkt_commit", 32'(packetCount), 1);
        check("t1_no_out_yet", 32'(outValid), 0);
        check("t1_level", 32'(level), 4);
        check("t1_aEmpty", 32'(almostEmpty), 0);
        for (int i = 0; i < 4; i++) begin
            step();
            check("t1_outValid", 32'(outValid), 1);
            check("t1_outData", 32'(outData), 32'hA0 + i);
            check("t1_outLast", 32'(outLast), 32'(i == 3));
        end
        step();
        check("t1_drained", 32'(outValid), 0);
        check("t1_pkt_zero", 32'(packetCount), 0);
        check("t1_level0", 32'(level), 0);
        check("t1_aEmpty1", 32'(almostEmpty), 1);

        // dropped 3-beat packet followed by good B0,B1
        beat(8'hD0, 1'b0, 1'b0);
        beat(8'hD1, 1'b0, 1'b0);
        beat(8'hD2, 1'b1, 1'b1);
        expDrops++;
        check("t2_dropPulse", 32'(dropPulse), 1);
        check("t2_level_rewind", 32'(level), 0);
        check("t2_pkt", 32'(packetCount), 0);
        beat(8'hB0, 1'b0, 1'b0);
        check("t2_pulse_once", 32'(dropPulse), 0);
        beat(8'hB1, 1'b1, 1'b0);
        step();
        check("t2_b0_valid", 32'(outValid), 1);
        check("t2_b0_data", 32'(outData), 32'hB0);
        check("t2_b0_last", 32'(outLast), 0);
        step();
        check("t2_b1_data", 32'(outData), 32'hB1);
        check("t2_b1_last", 32'(outLast), 1);
        step();
        check("t2_empty", 32'(outValid), 0);
        check("t2_level0", 32'(level), 0);
        check("t2_dropCount", 32'(dropCount), DcEn ? expDrops : 0);

        // oversize 20-beat packet: discarded after beat 16
        for (int i = 1; i <= 20; i++) begin
            check("t3_inReady", 32'(inReady), 1);
            beat(8'(i), i == 20, 1'b0);
            check("t3_no_out", 32'(outValid), 0);
            if (i == 16) check("t3_level_discard", 32'(level), 0);
        end
        expDrops++;
        check("t3_dropPulse", 32'(dropPulse), 1);
        check("t3_level0", 32'(level), 0);
        check("t3_pkt0", 32'(packetCount), 0);
        step();
        check("t3_pulse_end", 32'(dropPulse), 0);
        check("t3_still_empty", 32'(outValid), 0);
        check("t3_dropCount", 32'(dropCount), DcEn ? expDrops : 0);

        // fill with four 4-beat packets, output stalled
        outReady = 1'b0;
        for (int i = 0; i < 16; i++) beat(8'h40 + 8'(i), (i % 4) == 3, 1'b0);
        check("t4_level16", 32'(level), 16);
        check("t4_aFull", 32'(almostFull), 1);
        check("t4_pkt4", 32'(packetCount), 4);
        check("t4_rdy_one_free", 32'(inReady), 1);
        check("t4_head", 32'(outData), 32'h40);
        beat(8'h50, 1'b0, 1'b0);
        check("t4_full_rdy", 32'(inReady), 0);
        check("t4_level17", 32'(level), 17);
        outReady = 1'b1;
        step();
        outReady = 1'b0;
        check("t4_rdy_rise", 32'(inReady), 1);
        check("t4_next_head", 32'(outData), 32'h41);
        check("t4_level_after", 32'(level), 16);

        // reset mid-stream with two committed packets and a partial one
        resetN = 1'b0;
        step();
        resetN = 1'b1;
        expDrops = 0;
        step();
        beat(8'h60, 1'b0, 1'b0);
        beat(8'h61, 1'b1, 1'b0);
        beat(8'h62, 1'b0, 1'b0);
        beat(8'h63, 1'b1, 1'b0);
        beat(8'h64, 1'b0, 1'b0);
        check("t5_pkt2", 32'(packetCount), 2);
        resetN = 1'b0;
        step();
        checkReset("rst_mid");
        resetN = 1'b1;
        step();
        check("t5_rdy", 32'(inReady), 1);
        outReady = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("t5_no_stale", 32'(outValid), 0);
        end

        // three single-beat dropped packets
        for (int i = 0; i < 3; i++) begin
            beat(8'h70 + 8'(i), 1'b1, 1'b1);
            expDrops++;
            check("t6_dropPulse", 32'(dropPulse), 1);
        end
        step();
        check("t6_dropCount", 32'(dropCount), DcEn ? expDrops : 0);
        check("t6_no_out", 32'(outValid), 0);
        check("t6_level0", 32'(level), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
